// File: rtl/ahb_slave_bridge_if.sv
// AHB-lite slave port plus backend request/response channel
// for the posted-write AHB slave bridge.
interface ahb_slave_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WBUF_DEPTH = 4
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int LW = $clog2(WBUF_DEPTH) + 1;

  logic                  i_hselx;
  logic [1:0]            i_htrans;
  logic                  i_hwrite;
  logic [2:0]            i_hsize;
  logic [ADDR_WIDTH-1:0] i_haddr;
  logic [DATA_WIDTH-1:0] i_hwdata;
  logic                  i_hready;
  logic                  o_hreadyout;
  logic                  o_hresp;
  logic [DATA_WIDTH-1:0] o_hrdata;

  logic                  o_valid;
  logic                  i_ready;
  logic                  o_rd0_wr1;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic [SW-1:0]         o_wr_strb;
  logic                  i_rd_valid;
  logic [DATA_WIDTH-1:0] i_rd_data;
  logic [LW-1:0]         o_wbuf_level;

  modport slave (
    input  i_hselx, i_htrans, i_hwrite, i_hsize,
    input  i_haddr, i_hwdata, i_hready,
    output o_hreadyout, o_hresp, o_hrdata,
    output o_valid, o_rd0_wr1, o_addr,
    output o_wr_data, o_wr_strb, o_wbuf_level,
    input  i_ready, i_rd_valid, i_rd_data
  );

  modport master (
    output i_hselx, i_htrans, i_hwrite, i_hsize,
    output i_haddr, i_hwdata, i_hready,
    input  o_hreadyout, o_hresp, o_hrdata,
    input  o_valid, o_rd0_wr1, o_addr,
    input  o_wr_data, o_wr_strb, o_wbuf_level,
    output i_ready, i_rd_valid, i_rd_data
  );
endinterface

// File: rtl/ahb_slave_bridge.sv
// AHB-lite slave to valid/ready backend bridge with a posted-write
// FIFO; reads wait for the FIFO to drain to keep write-before-read.
module ahb_slave_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WBUF_DEPTH = 4
) (
  input logic i_clk_ahb,
  input logic i_rst_ahb,
  ahb_slave_bridge_if.slave bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int LG = $clog2(SW);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_RD_DRAIN, S_RD_REQ,
    S_RD_WAIT, S_ERR1, S_ERR2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;

  logic [ADDR_WIDTH-1:0] fa_mem [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] fd_mem [WBUF_DEPTH];
  logic [SW-1:0]         fs_mem [WBUF_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [LW-1:0]         cnt_q;

  logic                  empty, full, wr_issue;
  logic                  push, pop, can_push;
  logic                  acc, err, slot, rd_req;
  logic                  hready, hresp;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] amask;
  logic [SW-1:0]         strb;

  assign empty    = cnt_q == '0;
  assign full     = cnt_q == LW'(WBUF_DEPTH);
  assign wr_issue = !empty && state_q != S_RD_REQ
                    && state_q != S_RD_WAIT;
  assign pop      = wr_issue && bus.i_ready;
  assign can_push = !full || pop;
  assign push     = state_q == S_WDATA && can_push;
  assign acc      = bus.i_hselx && bus.i_hready
                    && bus.i_htrans[1];

  always_comb begin
    amask = (ADDR_WIDTH'(1) << bus.i_hsize) - ADDR_WIDTH'(1);
    err   = (bus.i_hsize > 3'(LG))
            || ((bus.i_haddr & amask) != '0);
  end

  // hsize bytes starting at the registered lane offset
  always_comb begin
    strb = '0;
    for (int b = 0; b < SW; b++) begin
      strb[b] = (b >= int'(addr_q[LG-1:0]))
                && (b < int'(addr_q[LG-1:0]) + (1 << size_q));
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    hready  = 1'b1;
    hresp   = 1'b0;
    rdata   = '0;
    rd_req  = 1'b0;
    slot    = 1'b0;
    unique case (state_q)
      S_IDLE: slot = 1'b1;
      S_WDATA: begin
        hready = can_push;
        slot   = can_push;
        if (can_push) state_d = S_IDLE;
      end
      S_RD_DRAIN: begin
        hready = 1'b0;
        if (empty) state_d = S_RD_REQ;
      end
      S_RD_REQ: begin
        hready = 1'b0;
        rd_req = 1'b1;
        if (bus.i_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        hready = bus.i_rd_valid;
        if (bus.i_rd_valid) begin
          rdata   = bus.i_rd_data;
          slot    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        hresp   = 1'b1;
        slot    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a completing data phase can take the next address phase
    if (slot && acc) begin
      addr_d = bus.i_haddr;
      size_d = bus.i_hsize;
      if (err)               state_d = S_ERR1;
      else if (bus.i_hwrite) state_d = S_WDATA;
      else                   state_d = S_RD_DRAIN;
    end
  end

  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk_ahb) begin
    if (push) begin
      fa_mem[wptr_q] <= addr_q;
      fd_mem[wptr_q] <= bus.i_hwdata;
      fs_mem[wptr_q] <= strb;
    end
  end

  assign bus.o_hreadyout  = hready;
  assign bus.o_hresp      = hresp;
  assign bus.o_hrdata     = rdata;
  assign bus.o_valid      = wr_issue || rd_req;
  assign bus.o_rd0_wr1    = wr_issue;
  assign bus.o_addr       = wr_issue ? fa_mem[rptr_q]
                          : rd_req   ? addr_q : '0;
  assign bus.o_wr_data    = wr_issue ? fd_mem[rptr_q] : '0;
  assign bus.o_wr_strb    = wr_issue ? fs_mem[rptr_q] : '0;
  assign bus.o_wbuf_level = cnt_q;
endmodule
